// File: rtl/alu_operand_stage.sv
// ============================================================================
// Module      : alu_operand_stage
// Description : Two-slot skid buffer between decode and ALU that selects the
//               ALU operands (rs1/pc, rs2/immediate) at capture time.
//               Optional writeback forwarding: define ALU_FORWARDING_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_operand_stage #(
  parameter int REGISTER_INDEX_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  // decode side
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [3:0]                      in_operation,
  input  logic [31:0]                     in_rs1_data,
  input  logic [31:0]                     in_rs2_data,
  input  logic [REGISTER_INDEX_WIDTH-1:0] in_rs1_index,
  input  logic [REGISTER_INDEX_WIDTH-1:0] in_rs2_index,
  input  logic [REGISTER_INDEX_WIDTH-1:0] in_rd,
  input  logic [31:0]                     in_immediate,
  input  logic [31:0]                     in_pc,
  input  logic                            in_operand_1_select,
  input  logic                            in_operand_2_select,
  // ALU side
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [3:0]                      operation,
  output logic signed [31:0]              operand_1,
  output logic signed [31:0]              operand_2,
  output logic [REGISTER_INDEX_WIDTH-1:0] out_rd,
  // writeback bus
  input  logic                            wb_valid,
  input  logic [REGISTER_INDEX_WIDTH-1:0] wb_rd,
  input  logic [31:0]                     wb_data
);

  // alu_operation_t encoding: Add is 4'd0, so an all-zero slot is the reset value
  localparam logic [3:0] ALU_ADD = 4'd0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]                      operation;
    logic [REGISTER_INDEX_WIDTH-1:0] rd;
    logic [31:0]                     operand_1;
    logic [31:0]                     operand_2;
`ifdef ALU_FORWARDING_EN
    logic [REGISTER_INDEX_WIDTH-1:0] rs1_index;
    logic [REGISTER_INDEX_WIDTH-1:0] rs2_index;
    logic                            operand_1_select;
    logic                            operand_2_select;
`endif
  } slot_t;

  state_t state, state_next;
  slot_t  main_slot, main_next;
  slot_t  skid_slot, skid_next;
  slot_t  captured;
  slot_t  main_patched, skid_patched;
  logic   accept, emit;
  logic [31:0] rs1_value, rs2_value;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

`ifdef ALU_FORWARDING_EN
  // Held register operands pick up a matching writeback; x0 is never forwarded.
  function automatic slot_t patch(input slot_t s, input logic v,
                                  input logic [REGISTER_INDEX_WIDTH-1:0] rd,
                                  input logic [31:0] data);
    slot_t p;
    p = s;
    if (v && (rd != '0)) begin
      if (!s.operand_1_select && (s.rs1_index == rd)) p.operand_1 = data;
      if (!s.operand_2_select && (s.rs2_index == rd)) p.operand_2 = data;
    end
    return p;
  endfunction

  assign rs1_value = (wb_valid && (wb_rd != '0) && (wb_rd == in_rs1_index)) ? wb_data : in_rs1_data;
  assign rs2_value = (wb_valid && (wb_rd != '0) && (wb_rd == in_rs2_index)) ? wb_data : in_rs2_data;
  assign main_patched = patch(main_slot, wb_valid, wb_rd, wb_data);
  assign skid_patched = patch(skid_slot, wb_valid, wb_rd, wb_data);
`else
  logic unused_forwarding_inputs;
  assign unused_forwarding_inputs = ^{wb_valid, wb_rd, wb_data, in_rs1_index, in_rs2_index};

  assign rs1_value    = in_rs1_data;
  assign rs2_value    = in_rs2_data;
  assign main_patched = main_slot;
  assign skid_patched = skid_slot;
`endif

  always_comb begin
    captured           = '0;
    captured.operation = in_operation;
    captured.rd        = in_rd;
    captured.operand_1 = in_operand_1_select ? in_pc        : rs1_value;
    captured.operand_2 = in_operand_2_select ? in_immediate : rs2_value;
`ifdef ALU_FORWARDING_EN
    captured.rs1_index        = in_rs1_index;
    captured.rs2_index        = in_rs2_index;
    captured.operand_1_select = in_operand_1_select;
    captured.operand_2_select = in_operand_2_select;
`endif
  end

  always_comb begin
    state_next = state;
    main_next  = main_patched;
    skid_next  = skid_patched;
    case (state)
      EMPTY: begin
        if (accept) begin
          main_next  = captured;
          state_next = ONE;
        end
      end
      ONE: begin
        if (accept && emit) begin
          main_next = captured;
        end else if (accept) begin
          skid_next  = captured;
          state_next = FULL;
        end else if (emit) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the skid-to-main move can happen
        if (emit) begin
          main_next  = skid_patched;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_slot <= '0;
      skid_slot <= '0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_next;
      main_slot <= main_next;
      skid_slot <= skid_next;
      in_ready  <= (state_next != FULL);
    end
  end

  assign out_valid = (state != EMPTY);
  assign operation = main_slot.operation;
  assign operand_1 = main_slot.operand_1;
  assign operand_2 = main_slot.operand_2;
  assign out_rd    = main_slot.rd;

endmodule

`default_nettype wire
